// File: rtl/npc_pkg.sv
//----------------------------------------------------------------------------
// Module : npc_pkg
// Brief  : Shared constants and fetch FSM state encoding for the NPC core.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package npc_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
//----------------------------------------------------------------------------
// Module : pc_next_sel
// Brief  : Next-PC select on retire (sequential vs redirect) plus misalign flag.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module pc_next_sel
  import npc_pkg::*;
#(
  parameter int XLEN = npc_pkg::XLEN
) (
  input  logic            i_retire,
  input  logic            i_halt_req,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misalign
);

  logic [XLEN-1:0] w_seq_pc;
  logic            w_take_redirect;

  assign w_seq_pc = i_pc + XLEN'(4);

  // A halting retire ignores the redirect entirely and just steps past the instruction.
  assign w_take_redirect = i_retire && !i_halt_req && i_redirect_valid;
  assign o_misalign      = w_take_redirect && (i_redirect_pc[1:0] != 2'b00);

  always_comb begin
    o_next_pc = i_pc;
    if (i_retire) begin
      o_next_pc = w_take_redirect ? i_redirect_pc : w_seq_pc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
//----------------------------------------------------------------------------
// Module : pc_fetch_ctrl
// Brief  : Architectural PC owner and single-outstanding instruction fetch sequencer.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module pc_fetch_ctrl #(
  parameter int XLEN = npc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = npc_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            halted,
  output logic            fetch_err
);

  import npc_pkg::*;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_fetch_err;

  logic            w_retire;
  logic            w_resp_ok;
  logic            w_resp_fault;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misalign;

  assign w_retire     = (r_state == S_HOLD) && inst_ready;
  assign w_resp_ok    = (r_state == S_WAIT) && imem_resp_valid && !imem_resp_err;
  assign w_resp_fault = (r_state == S_WAIT) && imem_resp_valid &&  imem_resp_err;

  pc_next_sel #(
    .XLEN (XLEN)
  ) u_pc_next_sel (
    .i_retire         (w_retire),
    .i_halt_req       (halt_req),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_pc             (r_pc),
    .o_next_pc        (w_next_pc),
    .o_misalign       (w_misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    halted         = 1'b0;
    case (r_state)
      S_BOOT: w_state_nxt = S_REQ;
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_resp_fault)   w_state_nxt = S_HALT;
        else if (w_resp_ok) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (w_retire) begin
          w_state_nxt = (halt_req || w_misalign) ? S_HALT : S_REQ;
        end
      end
      S_HALT:  halted = 1'b1;
      default: w_state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_inst_pc   <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (w_resp_ok) begin
        r_inst    <= imem_resp_data;
        r_inst_pc <= r_pc;
      end
      if (w_retire) begin
        r_pc <= w_next_pc;
      end
      if (w_resp_fault || w_misalign) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign imem_req_addr = r_pc;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign fetch_err     = r_fetch_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
//----------------------------------------------------------------------------
// Module : tb_pc_fetch_ctrl
// Brief  : Directed self-checking bench for pc_fetch_ctrl with request scoreboard.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        fetch_err;

  int          total;
  int          bad;
  logic [31:0] exp_q[$];

  pc_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt_req        (halt_req),
    .halted          (halted),
    .fetch_err       (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    halt_req        = 1'b0;
    step();
    step();
    chk("rst_req_valid",  imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_halted",     halted, 0);
    chk("rst_fetch_err",  fetch_err, 0);
    chk("rst_inst",       inst, 0);
    chk("rst_inst_pc",    inst_pc, 0);
    rst = 1'b1;
  endtask

  // Waits for a request, stalls it rdly cycles, accepts it, answers after wdly idle cycles.
  task automatic do_fetch(input logic [31:0] data, input int rdly, input int wdly, input bit err);
    int          n;
    logic [31:0] a0;
    logic [31:0] exp_a;
    n = 0;
    while (!imem_req_valid && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", imem_req_valid, 1);
    a0 = imem_req_addr;
    for (int i = 0; i < rdly; i++) begin
      step();
      chk("req_held",    imem_req_valid, 1);
      chk("addr_stable", imem_req_addr, a0);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    chk("req_addr", a0, exp_a);
    for (int i = 0; i < wdly; i++) begin
      chk("wait_no_inst", inst_valid, 0);
      chk("wait_no_req",  imem_req_valid, 0);
      step();
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    imem_resp_err   = err;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    if (!err) begin
      chk("inst_valid", inst_valid, 1);
      chk("inst_data",  inst, data);
      chk("inst_pc",    inst_pc, exp_a);
    end else begin
      chk("err_no_inst",   inst_valid, 0);
      chk("err_halted",    halted, 1);
      chk("err_fetch_err", fetch_err, 1);
    end
  endtask

  // Holds the instruction dly cycles with noise on redirect/halt, then retires it.
  task automatic do_retire(input bit h, input bit rv, input logic [31:0] rpc, input int dly);
    logic [31:0] i0;
    i0 = inst;
    for (int i = 0; i < dly; i++) begin
      halt_req       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0002;
      step();
      chk("hold_valid",   inst_valid, 1);
      chk("hold_stable",  inst, i0);
      chk("hold_no_halt", halted, 0);
    end
    inst_ready     = 1'b1;
    halt_req       = h;
    redirect_valid = rv;
    redirect_pc    = rpc;
    step();
    inst_ready     = 1'b0;
    halt_req       = 1'b0;
    redirect_valid = 1'b0;
    chk("retire_drop", inst_valid, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Basic fetch, 1-cycle latency, sequential retire.
    do_reset();
    step();
    chk("boot_req_valid", imem_req_valid, 1);
    chk("boot_req_addr",  imem_req_addr, 32'h8000_0000);
    exp_q.push_back(32'h8000_0000);
    do_fetch(32'h0000_0013, 0, 0, 1'b0);
    do_retire(1'b0, 1'b0, '0, 0);
    exp_q.push_back(32'h8000_0004);

    // Stalled request and slow response.
    do_fetch(32'h0010_0093, 3, 5, 1'b0);

    // Redirect, then misaligned redirect.
    do_retire(1'b0, 1'b1, 32'h8000_0100, 2);
    exp_q.push_back(32'h8000_0100);
    do_fetch(32'h0020_0113, 0, 1, 1'b0);
    do_retire(1'b0, 1'b1, 32'h8000_0102, 0);
    chk("mis_halted",    halted, 1);
    chk("mis_fetch_err", fetch_err, 1);
    chk("mis_pc",        imem_req_addr, 32'h8000_0102);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mis_no_req", imem_req_valid, 0);
    end

    // Halt wins over redirect.
    do_reset();
    exp_q.push_back(32'h8000_0000);
    do_fetch(32'h0010_0073, 0, 0, 1'b0);
    do_retire(1'b1, 1'b1, 32'h8000_0200, 0);
    chk("halt_halted",    halted, 1);
    chk("halt_fetch_err", fetch_err, 0);
    chk("halt_pc",        imem_req_addr, 32'h8000_0004);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_no_req", imem_req_valid, 0);
      chk("halt_sticky", halted, 1);
    end

    // Access fault.
    do_reset();
    exp_q.push_back(32'h8000_0000);
    do_fetch(32'hFFFF_FFFF, 0, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fault_no_inst", inst_valid, 0);
      chk("fault_no_req",  imem_req_valid, 0);
    end

    // Reset in S_WAIT, late response ignored; then PC wrap.
    do_reset();
    step();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_req", imem_req_valid, 0);
    step();
    rst             = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    step();
    imem_resp_valid = 1'b0;
    chk("late_no_inst", inst_valid, 0);
    chk("late_req",     imem_req_valid, 1);
    chk("late_inst",    inst, 0);
    exp_q.push_back(32'h8000_0000);
    do_fetch(32'h0000_0013, 0, 0, 1'b0);
    do_retire(1'b0, 1'b1, 32'hFFFF_FFFC, 0);
    exp_q.push_back(32'hFFFF_FFFC);
    do_fetch(32'h0000_0033, 0, 0, 1'b0);
    do_retire(1'b0, 1'b0, '0, 1);
    exp_q.push_back(32'h0000_0000);
    do_fetch(32'h0000_0013, 1, 0, 1'b0);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
